// File: rtl/soc_irq_ctrl.sv
// soc_irq_ctrl: edge-capturing, masked, fixed-priority interrupt controller with claim/EOI sequencing.
// Define IRQ_LEVEL_EN to make PEND follow src_done levels instead of latching rising edges.
module soc_irq_ctrl #(
  parameter int N_SRC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [N_SRC-1:0] src_done,
  output logic             irq
);
  localparam logic [1:0] IDLE = 2'b00, ARMED = 2'b01, SERVICE = 2'b10;
  logic [N_SRC-1:0] pend, mask, src_prev, hit, pend_n;
  logic [1:0] state, state_n;
  logic [2:0] active, id;
  logic valid, wr, wr_mask, wr_claim, wr_eoi, claim_ok, unused;
  assign wr = sel & we;
  assign wr_mask = wr && addr == 2'd1;
  assign wr_claim = wr && addr == 2'd2;
  assign wr_eoi = wr && addr == 2'd3;
  assign hit = pend & mask;
  assign valid = |hit;
  assign claim_ok = state == ARMED && wr_claim && valid;
  always_comb begin
    id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (hit[i]) id = 3'(i);
  end
`ifdef IRQ_LEVEL_EN
  assign pend_n = src_done;
  assign unused = &{1'b0, wdata[31:N_SRC], src_prev};
`else
  logic [N_SRC-1:0] w1c, clr;
  assign w1c = (wr && addr == 2'd0) ? wdata[N_SRC-1:0] : '0;
  assign clr = claim_ok ? N_SRC'(1) << id : '0;
  // a rise beats W1C on the same bit, but the claimed bit is always cleared
  assign pend_n = ((pend & ~w1c) | (src_done & ~src_prev)) & ~clr;
  assign unused = &{1'b0, wdata[31:N_SRC]};
`endif
  always_comb
    state_n = state == IDLE  ? (valid ? ARMED : IDLE) :
              state == ARMED ? (claim_ok ? SERVICE : valid ? ARMED : IDLE) :
              state == SERVICE ? (wr_eoi ? IDLE : SERVICE) : IDLE;
  always_ff @(posedge clk) begin
    src_prev <= src_done;
    if (reset) begin
      pend   <= '0;
      mask   <= '0;
      active <= '0;
      state  <= IDLE;
      irq    <= 1'b0;
    end else begin
      pend  <= pend_n;
      state <= state_n;
      irq   <= state == ARMED;
      if (wr_mask) mask <= wdata[N_SRC-1:0];
      if (claim_ok) active <= id;
    end
  end
  always_comb
    rdata = !sel         ? 32'd0 :
            addr == 2'd0 ? 32'(pend) :
            addr == 2'd1 ? 32'(mask) :
            addr == 2'd2 ? {state, 21'd0, valid, 5'd0, id} : {29'd0, active};
endmodule

// File: tb/tb_soc_irq_ctrl.sv
// tb_soc_irq_ctrl: table vectors, hand sequences and random traffic against a behavioural model.
module tb_soc_irq_ctrl;
  localparam int N = 2;
  localparam int ALL = (1 << N) - 1;
  logic clk = 0, reset = 1, sel = 0, we = 0, irq;
  logic [1:0] addr = 0;
  logic [31:0] wdata = 0, rdata;
  logic [N-1:0] src_done = 0;
  int n_vec = 0, n_err = 0;
  int m_pend, m_mask, m_act, m_st, m_irq, m_prev;

  soc_irq_ctrl #(.N_SRC(N)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .src_done(src_done), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sel, we;
    logic [1:0] addr;
    logic [31:0] wdata;
    logic [1:0] src;
    logic [31:0] rd;
    logic irq;
  } vec_t;
  vec_t tv[20];

  function automatic int first_set(int v);
    for (int k = 0; k < N; k++) if (((v >> k) & 1) != 0) return k;
    return 0;
  endfunction

  function automatic logic [31:0] m_read();
    int hit = m_pend & m_mask;
    if (!sel) return 0;
    case (addr)
      2'd0: return m_pend;
      2'd1: return m_mask;
      2'd2: return (m_st << 30) | ((hit != 0 ? 1 : 0) << 8) | first_set(hit);
      default: return m_act;
    endcase
  endfunction

  task automatic m_step();
    int hit, id, np;
    bit wr, vld;
    if (reset) begin
      m_pend = 0; m_mask = 0; m_act = 0; m_st = 0; m_irq = 0; m_prev = int'(src_done);
      return;
    end
    wr = sel && we;
    hit = m_pend & m_mask;
    vld = hit != 0;
    id = first_set(hit);
    m_irq = (m_st == 1) ? 1 : 0;
`ifdef IRQ_LEVEL_EN
    np = int'(src_done);
`else
    np = m_pend;
    if (wr && addr == 0) np = np & ~int'(wdata);
    np = (np | (int'(src_done) & ~m_prev)) & ALL;
`endif
    m_prev = int'(src_done);
    if (m_st == 0 && vld) m_st = 1;
    else if (m_st == 1) begin
      if (wr && addr == 2 && vld) begin
        m_act = id;
`ifndef IRQ_LEVEL_EN
        np = np & ~(1 << id);
`endif
        m_st = 2;
      end else if (!vld) m_st = 0;
    end else if (m_st == 2 && wr && addr == 3) m_st = 0;
    if (wr && addr == 1) m_mask = int'(wdata) & ALL;
    m_pend = np;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic w, input logic [1:0] a,
                       input logic [31:0] d, input logic [1:0] src);
    reset = r; sel = s; we = w; addr = a; wdata = d; src_done = src;
    #1;
  endtask

  task automatic tick();
    chk("model_rdata", rdata, m_read());
    chk("model_irq", {31'd0, irq}, m_irq[31:0]);
    @(posedge clk);
    m_step();
    #1;
  endtask

  function automatic vec_t mk(logic s, logic w, logic [1:0] a, logic [31:0] d, logic [1:0] src,
                              logic [31:0] rd, logic i);
    vec_t v;
    v.sel = s; v.we = w; v.addr = a; v.wdata = d; v.src = src; v.rd = rd; v.irq = i;
    return v;
  endfunction

  initial begin
    logic [1:0] rs;
    tv[0]  = mk(1, 1, 1, 3, 0, 0, 0);
    tv[1]  = mk(1, 0, 1, 0, 2, 3, 0);
    tv[2]  = mk(1, 0, 0, 0, 2, 2, 0);
    tv[3]  = mk(1, 0, 2, 0, 2, 32'h4000_0101, 0);
    tv[4]  = mk(1, 0, 2, 0, 2, 32'h4000_0101, 1);
    tv[5]  = mk(1, 1, 2, 0, 2, 32'h4000_0101, 1);
    tv[6]  = mk(1, 0, 3, 0, 2, 1, 1);
    tv[7]  = mk(1, 0, 2, 0, 2, 32'h8000_0000, 0);
    tv[8]  = mk(1, 1, 3, 0, 2, 1, 0);
    tv[9]  = mk(1, 0, 2, 0, 2, 0, 0);
    tv[10] = mk(0, 0, 2, 0, 2, 0, 0);
    tv[11] = mk(1, 1, 1, 0, 0, 3, 0);
    tv[12] = mk(1, 0, 0, 0, 1, 0, 0);
    tv[13] = mk(1, 0, 0, 0, 1, 1, 0);
    tv[14] = mk(1, 1, 1, 1, 1, 0, 0);
    tv[15] = mk(1, 0, 2, 0, 1, 32'h0000_0100, 0);
    tv[16] = mk(1, 0, 2, 0, 0, 32'h4000_0100, 0);
    tv[17] = mk(1, 1, 0, 1, 1, 1, 1);
    tv[18] = mk(1, 0, 0, 0, 1, 1, 1);
    tv[19] = mk(1, 0, 2, 0, 1, 32'h4000_0100, 1);

    drive(1, 0, 0, 0, 0, 0);
    repeat (2) begin @(posedge clk); m_step(); #1; end
    drive(0, 1, 0, 1, 0, 0);
    chk("rst_mask", rdata, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    tick();
`ifndef IRQ_LEVEL_EN
    foreach (tv[i]) begin
      drive(0, tv[i].sel, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].src);
      chk($sformatf("tbl%0d_rdata", i), rdata, tv[i].rd);
      chk($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tv[i].irq});
      tick();
    end
    // simultaneous rises: src 0 wins, src 1 rearms after EOI
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 1, 3, 0); tick();
    drive(0, 1, 0, 0, 0, 3); tick();
    drive(0, 1, 0, 0, 0, 3); tick();
    drive(0, 1, 0, 0, 0, 3); tick();
    drive(0, 1, 1, 2, 0, 3); tick();
    drive(0, 1, 0, 3, 0, 3); chk("t2_id0", rdata, 0); tick();
    drive(0, 1, 0, 0, 0, 3); chk("t2_pend", rdata, 2); chk("t2_irq0", {31'd0, irq}, 0); tick();
    drive(0, 1, 1, 3, 0, 3); tick();
    drive(0, 1, 0, 2, 0, 3); tick();
    drive(0, 1, 0, 2, 0, 3); tick();
    drive(0, 1, 0, 2, 0, 3); chk("t2_rearm", rdata, 32'h4000_0101); chk("t2_irq1", {31'd0, irq}, 1); tick();
    drive(0, 1, 1, 2, 0, 3); tick();
    drive(0, 1, 0, 3, 0, 3); chk("t2_id1", rdata, 1); tick();
    // reset mid-service with src_done held high
    drive(1, 1, 0, 2, 0, 3); tick();
    drive(0, 1, 0, 2, 0, 3); chk("t5_state", rdata, 0); chk("t5_irq", {31'd0, irq}, 0); tick();
    drive(0, 1, 1, 3, 0, 3); tick();
    drive(0, 1, 0, 2, 0, 3); chk("t5_eoi_ign", rdata, 0); tick();
    drive(0, 1, 0, 0, 0, 3); chk("t5_no_rise", rdata, 0); tick();
    drive(0, 1, 0, 1, 0, 3); chk("t5_mask", rdata, 0); tick();
`else
    drive(0, 1, 1, 1, 1, 1); tick();
    drive(0, 1, 0, 0, 0, 1); tick();
    drive(0, 1, 0, 0, 0, 1); tick();
    drive(0, 1, 1, 2, 0, 1); tick();
    drive(0, 1, 0, 2, 0, 1); chk("t6_service", rdata, 32'h8000_0100); tick();
    drive(0, 1, 1, 3, 0, 1); tick();
    drive(0, 1, 0, 2, 0, 1); tick();
    drive(0, 1, 0, 2, 0, 1); chk("t6_rearm", rdata, 32'h4000_0100); tick();
    drive(0, 1, 1, 2, 0, 1); tick();
    drive(0, 1, 0, 2, 0, 0); tick();
    drive(0, 1, 1, 3, 0, 0); tick();
    drive(0, 1, 0, 2, 0, 0); tick();
    drive(0, 1, 0, 2, 0, 0); chk("t6_idle", rdata, 0); tick();
`endif
    rs = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rs = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), $urandom, rs);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
